// File: rtl/ps_ustack.sv
// LIFO data stack on the ureg bus: push from bus connect, registered pop data,
// full/empty status and sticky overflow/underflow flags for the status register.
module ps_ustack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps_pshstck,
    input  logic                     ps_popstck,
    input  logic [WIDTH-1:0]         ps_stck_din,
    input  logic                     ps_stck_clr,
    output logic [WIDTH-1:0]         ps_stck_dout,
    output logic                     ps_stck_dout_vld,
    output logic                     ps_stck_empty,
    output logic                     ps_stck_full,
    output logic [$clog2(DEPTH):0]   ps_stck_cnt,
    output logic                     ps_stck_ovf,
    output logic                     ps_stck_unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [PW-1:0]    top_idx, wr_idx;
    logic             wr_en, empty, full, ovf_evt, unf_evt;
    logic [WIDTH-1:0] dout;
    logic             dout_vld, ovf, unf;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    // Low pointer bits wrap to DEPTH-1 when full, which is exactly the top entry.
    assign top_idx = cnt[PW-1:0] - PW'(1);

    always_comb begin
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = cnt[PW-1:0];
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (ps_popstck) begin
            if (empty) begin
                unf_evt = 1'b1;
                if (ps_pshstck) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_nxt = CW'(1);
                end
            end else if (ps_pshstck) begin
                // Pop-then-push replaces the top entry; depth is unchanged.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end else if (ps_pshstck) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dout_vld <= ps_popstck && !empty;
            if (ps_popstck) begin
                dout <= empty ? '0 : mem[top_idx];
            end
            ovf <= ovf_evt | (ovf & ~ps_stck_clr);
            unf <= unf_evt | (unf & ~ps_stck_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= ps_stck_din;
        end
    end

    assign ps_stck_dout     = dout;
    assign ps_stck_dout_vld = dout_vld;
    assign ps_stck_empty    = empty;
    assign ps_stck_full     = full;
    assign ps_stck_cnt      = cnt;
    assign ps_stck_ovf      = ovf;
    assign ps_stck_unf      = unf;
endmodule

// File: tb/tb_ps_ustack.sv
// Bench for ps_ustack: queue-based stack model checked every cycle, directed
// scenarios with literal expectations, then randomized push/pop/clear traffic.
module tb_ps_ustack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_vld, empty, full, ovf, unf;
    logic [3:0]       cnt;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    ps_ustack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ps_pshstck(push), .ps_popstck(pop),
        .ps_stck_din(din), .ps_stck_clr(clr),
        .ps_stck_dout(dout), .ps_stck_dout_vld(dout_vld),
        .ps_stck_empty(empty), .ps_stck_full(full),
        .ps_stck_cnt(cnt), .ps_stck_ovf(ovf), .ps_stck_unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic c);
        logic oe, ue;
        oe = 1'b0; ue = 1'b0; m_vld = 1'b0;
        if (o) begin
            if (q.size() > 0) begin
                m_dout = q.pop_back();
                m_vld  = 1'b1;
            end else begin
                m_dout = '0;
                ue     = 1'b1;
            end
        end
        if (p) begin
            if (o || q.size() < DEPTH) q.push_back(d);
            else oe = 1'b1;
        end
        m_ovf = oe | (m_ovf & ~c);
        m_unf = ue | (m_unf & ~c);
    endtask

    // Inputs change 1 time unit after a rising edge; the model advances at that edge.
    task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic c);
        push = p; pop = o; din = d; clr = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            chk("cnt",   32'(cnt),      32'(q.size()));
            chk("empty", 32'(empty),    32'(q.size() == 0));
            chk("full",  32'(full),     32'(q.size() == DEPTH));
            chk("vld",   32'(dout_vld), 32'(m_vld));
            chk("dout",  32'(dout),     32'(m_dout));
            chk("ovf",   32'(ovf),      32'(m_ovf));
            chk("unf",   32'(unf),      32'(m_unf));
        end
    end

    initial begin
        model_reset();
        #1;
        chk("rst_cnt",   32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_dout",  32'(dout), 0);
        chk("rst_vld",   32'(dout_vld), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // three pushes then three pops
        step(1, 0, 16'h1111, 0);
        step(1, 0, 16'h2222, 0);
        step(1, 0, 16'h3333, 0);
        chk("t1_cnt", 32'(cnt), 3);
        chk("t1_empty", 32'(empty), 0);
        step(0, 1, 0, 0); chk("t1_pop0", 32'(dout), 32'h3333); chk("t1_vld0", 32'(dout_vld), 1);
        step(0, 1, 0, 0); chk("t1_pop1", 32'(dout), 32'h2222);
        step(0, 1, 0, 0); chk("t1_pop2", 32'(dout), 32'h1111);
        chk("t1_cnt0", 32'(cnt), 0);
        chk("t1_empty1", 32'(empty), 1);
        step(0, 0, 0, 0); chk("t1_vld_off", 32'(dout_vld), 0); chk("t1_hold", 32'(dout), 32'h1111);

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, 16'h0A00 + 16'(i), 0);
        step(1, 0, 16'hBEEF, 0);
        chk("t2_full", 32'(full), 1);
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_cnt", 32'(cnt), 8);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 0, 0);
            chk("t2_pop", 32'(dout), 32'h0A07 - 32'(i));
        end

        // underflow and sticky clear
        step(0, 1, 0, 0);
        chk("t3_unf", 32'(unf), 1); chk("t3_dout", 32'(dout), 0);
        chk("t3_vld", 32'(dout_vld), 0); chk("t3_cnt", 32'(cnt), 0);
        step(0, 0, 0, 1); chk("t3_clr", 32'(unf), 0); chk("t3_ovfclr", 32'(ovf), 0);
        step(0, 1, 0, 1); chk("t3_setwins", 32'(unf), 1);
        step(0, 0, 0, 1);

        // replace top with simultaneous push+pop
        step(1, 0, 16'h0001, 0);
        step(1, 0, 16'h0002, 0);
        step(1, 1, 16'h00FF, 0);
        chk("t4_dout", 32'(dout), 32'h0002); chk("t4_vld", 32'(dout_vld), 1); chk("t4_cnt", 32'(cnt), 2);
        step(0, 1, 0, 0); chk("t4_pop", 32'(dout), 32'h00FF);
        step(0, 1, 0, 0); chk("t4_pop2", 32'(dout), 32'h0001);

        // push+pop on empty
        step(1, 1, 16'h5555, 0);
        chk("t5_unf", 32'(unf), 1); chk("t5_vld", 32'(dout_vld), 0); chk("t5_cnt", 32'(cnt), 1);
        step(0, 1, 0, 0); chk("t5_pop", 32'(dout), 32'h5555);
        step(0, 0, 0, 1);

        // push+pop when full, then async reset mid-cycle
        for (int i = 0; i < DEPTH; i++) step(1, 0, 16'(16'hC000 + i), 0);
        step(1, 1, 16'h7777, 0);
        chk("t6_ovf", 32'(ovf), 0); chk("t6_cnt", 32'(cnt), 8); chk("t6_dout", 32'(dout), 32'hC007);
        step(0, 1, 0, 0); chk("t6_newtop", 32'(dout), 32'h7777);
        step(0, 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("t6_rcnt", 32'(cnt), 0); chk("t6_rempty", 32'(empty), 1);
        chk("t6_rdout", 32'(dout), 0); chk("t6_rovf", 32'(ovf), 0); chk("t6_runf", 32'(unf), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized traffic with alternating fill/drain bias
        for (int n = 0; n < 3000; n++) begin
            int pb;
            pb = ((n / 150) % 2 == 0) ? 70 : 30;
            step(logic'($urandom_range(0, 99) < pb),
                 logic'($urandom_range(0, 99) < (100 - pb)),
                 WIDTH'($urandom),
                 logic'($urandom_range(0, 99) < 5));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
